// File: rtl/frame_buf_pkg.sv
// Shared constants for the frame buffer arbiter: FSM encodings, bank count,
// default burst and frame sizes.
package frame_buf_pkg;

  localparam int NUM_BANKS       = 2;
  localparam int DEF_BURST_LEN   = 256;
  localparam int DEF_FRAME_WORDS = 393216;

  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_WR_REQ  = 3'd2;
  localparam logic [2:0] S_WR_BUSY = 3'd3;
  localparam logic [2:0] S_RD_REQ  = 3'd4;
  localparam logic [2:0] S_RD_BUSY = 3'd5;

endpackage

// File: rtl/fba_addr_gen.sv
// Per-direction burst address generator: tracks the word offset inside the
// current frame and forms bank base + offset. One instance for write, one for read.
module fba_addr_gen
  import frame_buf_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(NUM_BANKS)-1:0] bank,
  input  logic                         advance,
  input  logic                         clear,
  output logic [ADDR_W-1:0]            addr,
  output logic                         complete
);

  localparam logic [ADDR_W-1:0] FW = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BL = ADDR_W'(BURST_LEN);

  logic [ADDR_W-1:0] offset;

  // Offset restarts on a new frame and steps one burst per finished burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     offset <= '0;
    else if (clear)                 offset <= '0;
    else if (advance && !complete)  offset <= offset + BL;
  end

  assign complete = (offset == FW);
  assign addr     = ADDR_W'(bank) * FW + offset;

endmodule

// File: rtl/frame_buf_arbiter.sv
// Double-banked frame buffer arbiter: camera writes fill one bank while the
// Ethernet reader drains the last completed one. Bursts are serialized to a
// single outstanding memory request.
// Optional macro FRAME_BUF_ARBITER_STATS_EN enables frame/drop counters.
module frame_buf_arbiter
  import frame_buf_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int LVL_W       = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_init_done,
  input  logic              cap_frame_start,
  input  logic [LVL_W-1:0]  cap_fifo_level,
  input  logic              eth_frame_req,
  input  logic [LVL_W-1:0]  eth_fifo_space,
  output logic              mem_wr_req,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_done,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              frame_ready,
  output logic [15:0]       cap_frame_cnt,
  output logic [15:0]       drop_cnt
);

  localparam logic [31:0] BL1 = 32'(BURST_LEN);
  localparam logic [31:0] BL2 = 32'(2 * BURST_LEN);

  logic [2:0]        state;
  logic              cap_pend, eth_pend;
  logic              wr_active, rd_active, last_done, rr_wr;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              wr_cmpl, rd_cmpl;
  logic              wr_elig, rd_elig, wr_urgent, idle_arb, grant_wr, grant_rd;
  logic              cap_apply, eth_apply, rd_clr, wr_adv, rd_adv, wr_swap;

  // Pending frame events are only acted on in IDLE, and they take the whole
  // IDLE cycle so arbitration always sees the updated frame state.
  assign cap_apply = (state == S_IDLE) && cap_pend;
  assign eth_apply = (state == S_IDLE) && eth_pend;
  assign rd_clr    = eth_apply && frame_ready;
  assign idle_arb  = (state == S_IDLE) && !cap_pend && !eth_pend;

  assign wr_elig   = wr_active && !wr_cmpl && (32'(cap_fifo_level) >= BL1);
  assign rd_elig   = rd_active && !rd_cmpl && (32'(eth_fifo_space) >= BL1);
  assign wr_urgent = 32'(cap_fifo_level) >= BL2;
  assign grant_wr  = idle_arb && wr_elig && (wr_urgent || !rd_elig || rr_wr);
  assign grant_rd  = idle_arb && rd_elig && !grant_wr;

  assign wr_adv = (state == S_WR_BUSY) && mem_done;
  assign rd_adv = (state == S_RD_BUSY) && mem_done;

  // Toggle to the other bank unless the reader is still draining it.
  assign wr_swap = !((~wr_bank) == rd_bank && rd_active && !rd_cmpl);

  fba_addr_gen #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS)) u_wr_gen (
    .clk(clk), .rst_n(rst_n), .bank(wr_bank), .advance(wr_adv), .clear(cap_apply),
    .addr(wr_addr), .complete(wr_cmpl)
  );

  fba_addr_gen #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS)) u_rd_gen (
    .clk(clk), .rst_n(rst_n), .bank(rd_bank), .advance(rd_adv), .clear(rd_clr),
    .addr(rd_addr), .complete(rd_cmpl)
  );

  // Burst FSM: issue one request, hold address until ack, wait for done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      mem_wr_req <= 1'b0;
      mem_rd_req <= 1'b0;
      mem_addr   <= '0;
      rr_wr      <= 1'b1;
    end else begin
      case (state)
        S_INIT:    if (mem_init_done) state <= S_IDLE;
        S_IDLE: begin
          if (grant_wr) begin
            state      <= S_WR_REQ;
            mem_wr_req <= 1'b1;
            mem_addr   <= wr_addr;
            rr_wr      <= 1'b0;
          end else if (grant_rd) begin
            state      <= S_RD_REQ;
            mem_rd_req <= 1'b1;
            mem_addr   <= rd_addr;
            rr_wr      <= 1'b1;
          end
        end
        S_WR_REQ:  if (mem_ack) begin state <= S_WR_BUSY; mem_wr_req <= 1'b0; end
        S_WR_BUSY: if (mem_done) state <= S_IDLE;
        S_RD_REQ:  if (mem_ack) begin state <= S_RD_BUSY; mem_rd_req <= 1'b0; end
        S_RD_BUSY: if (mem_done) state <= S_IDLE;
        default:   state <= S_INIT;
      endcase
    end
  end

  // Frame bookkeeping: pending events, bank selection, ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_pend    <= 1'b0;
      eth_pend    <= 1'b0;
      wr_active   <= 1'b0;
      rd_active   <= 1'b0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      last_done   <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      cap_pend <= cap_frame_start | (cap_pend & ~cap_apply);
      eth_pend <= eth_frame_req | (eth_pend & ~eth_apply);
      if (rd_clr) begin
        rd_bank     <= last_done;
        rd_active   <= 1'b1;
        frame_ready <= 1'b0;
      end
      if (cap_apply) begin
        wr_active <= 1'b1;
        if (wr_active && wr_cmpl) begin
          last_done   <= wr_bank;
          frame_ready <= 1'b1;
          if (wr_swap) wr_bank <= ~wr_bank;
        end
      end
    end
  end

`ifdef FRAME_BUF_ARBITER_STATS_EN
  logic [15:0] cap_cnt_q, drop_cnt_q;

  // Saturating counts of applied frame starts and abandoned partial frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (cap_apply) begin
      if (cap_cnt_q != 16'hFFFF) cap_cnt_q <= cap_cnt_q + 16'd1;
      if (wr_active && !wr_cmpl && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign cap_frame_cnt = cap_cnt_q;
  assign drop_cnt      = drop_cnt_q;
`else
  assign cap_frame_cnt = '0;
  assign drop_cnt      = '0;
`endif

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Bench for frame_buf_arbiter with default parameters.
module tb_frame_buf_arbiter;

  localparam int AW = 22;
  localparam int BL = 256;
  localparam int FW = 393216;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst_n, mem_init_done, cap_frame_start, eth_frame_req, mem_ack, mem_done;
  logic [LW-1:0] cap_fifo_level, eth_fifo_space;
  logic          mem_wr_req, mem_rd_req, wr_bank, rd_bank, frame_ready;
  logic [AW-1:0] mem_addr;
  logic [15:0]   cap_frame_cnt, drop_cnt;

  always #5 clk = ~clk;

  frame_buf_arbiter dut (
    .clk(clk), .rst_n(rst_n), .mem_init_done(mem_init_done),
    .cap_frame_start(cap_frame_start), .cap_fifo_level(cap_fifo_level),
    .eth_frame_req(eth_frame_req), .eth_fifo_space(eth_fifo_space),
    .mem_wr_req(mem_wr_req), .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_done(mem_done), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .frame_ready(frame_ready), .cap_frame_cnt(cap_frame_cnt), .drop_cnt(drop_cnt)
  );

  int errs = 0, checks = 0;

  // Reference state of the frame buffer.
  bit m_wr_act, m_rd_act, m_wr_bank, m_rd_bank, m_ready, m_last, m_last_wr;
  int m_wr_off, m_rd_off, m_drop, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wr_act = 0; m_rd_act = 0; m_wr_bank = 0; m_rd_bank = 0; m_ready = 0;
    m_last = 0; m_last_wr = 0; m_wr_off = 0; m_rd_off = 0; m_drop = 0; m_cnt = 0;
  endtask

  task automatic model_frame_start();
    if (m_wr_act && m_wr_off == FW) begin
      m_last  = m_wr_bank;
      m_ready = 1;
      if (!((!m_wr_bank) == m_rd_bank && m_rd_act && m_rd_off < FW)) m_wr_bank = !m_wr_bank;
    end else if (m_wr_act) begin
      m_drop++;
    end
    m_wr_act = 1;
    m_wr_off = 0;
    m_cnt++;
  endtask

  task automatic model_eth();
    if (m_ready) begin
      m_rd_bank = m_last; m_rd_off = 0; m_rd_act = 1; m_ready = 0;
    end
  endtask

  function automatic int exp_cnt(input int v);
`ifdef FRAME_BUF_ARBITER_STATS_EN
    return (v > 65535) ? 65535 : v;
`else
    return 0 * v;
`endif
  endfunction

  // 0 = write, 1 = read, 2 = nothing eligible
  function automatic int predict(input int cap, input int space);
    bit we, re;
    we = m_wr_act && m_wr_off < FW && cap >= BL;
    re = m_rd_act && m_rd_off < FW && space >= BL;
    if (we && cap >= 2 * BL) return 0;
    if (we && re)            return m_last_wr ? 1 : 0;
    if (we)                  return 0;
    if (re)                  return 1;
    return 2;
  endfunction

  // Memory side of one burst, with ignored stray ack/done pulses.
  task automatic serve(input int ek, input int ea, input bit mid, output int okind);
    int n = 0;
    okind = -1;
    while (!(mem_wr_req || mem_rd_req) && n < 40) begin @(negedge clk); n++; end
    if (!(mem_wr_req || mem_rd_req)) begin
      chk("req_timeout", mem_wr_req | mem_rd_req, 1);
      cap_fifo_level = '0; eth_fifo_space = '0;
      return;
    end
    okind = mem_rd_req ? 1 : 0;
    chk("req_exclusive", mem_wr_req & mem_rd_req, 0);
    chk("req_kind", mem_rd_req, ek == 1);
    chk("req_addr", mem_addr, ea);
    repeat (int'($urandom_range(2, 0))) begin
      mem_done = ($urandom_range(1, 0) == 1);
      @(negedge clk);
      mem_done = 1'b0;
      chk("req_hold", {mem_rd_req, mem_wr_req}, (ek == 1) ? 2 : 1);
      chk("addr_hold", mem_addr, ea);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("req_release", mem_wr_req | mem_rd_req, 0);
    if (mid) begin
      cap_frame_start = 1'b1;
      @(negedge clk);
      cap_frame_start = 1'b0;
      chk("busy_bank_hold", wr_bank, m_wr_bank);
      chk("busy_ready_hold", frame_ready, m_ready);
    end
    repeat (int'($urandom_range(3, 0))) begin
      mem_ack = ($urandom_range(1, 0) == 1);
      @(negedge clk);
      mem_ack = 1'b0;
      chk("busy_no_req", mem_wr_req | mem_rd_req, 0);
    end
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    cap_fifo_level = '0;
    eth_fifo_space = '0;
  endtask

  task automatic next_burst(input int cap, input int space, input bit mid, input int pat);
    int g, ea, ok;
    cap_fifo_level = LW'(cap);
    eth_fifo_space = LW'(space);
    g  = predict(cap, space);
    ea = (g == 1) ? (int'(m_rd_bank) * FW + m_rd_off) : (int'(m_wr_bank) * FW + m_wr_off);
    serve(g, ea, mid, ok);
    if (pat >= 0) chk("rr_pattern", ok, pat);
    if (g == 0)      begin m_wr_off += BL; m_last_wr = 1; end
    else if (g == 1) begin m_rd_off += BL; m_last_wr = 0; end
  endtask

  task automatic pulse_cap();
    cap_frame_start = 1'b1; @(negedge clk); cap_frame_start = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic pulse_eth();
    eth_frame_req = 1'b1; @(negedge clk); eth_frame_req = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic chk_frame(input string tag);
    chk({tag, "_wr_bank"}, wr_bank, m_wr_bank);
    chk({tag, "_rd_bank"}, rd_bank, m_rd_bank);
    chk({tag, "_ready"}, frame_ready, m_ready);
    chk({tag, "_cap_cnt"}, cap_frame_cnt, exp_cnt(m_cnt));
    chk({tag, "_drop_cnt"}, drop_cnt, exp_cnt(m_drop));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; mem_init_done = 1'b0; cap_frame_start = 1'b0; eth_frame_req = 1'b0;
    mem_ack = 1'b0; mem_done = 1'b0; cap_fifo_level = '0; eth_fifo_space = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_wr_req", mem_wr_req, 0);
    chk("rst_rd_req", mem_rd_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk_frame("rst");

    // Memory not ready: a pending frame start must not produce a request.
    rst_n = 1'b1;
    @(negedge clk);
    pulse_cap();
    cap_fifo_level = LW'(256);
    repeat (8) begin @(negedge clk); chk("init_no_req", mem_wr_req | mem_rd_req, 0); end
    mem_init_done = 1'b1;
    model_frame_start();
    next_burst(256, 0, 0, 0);
    for (int i = 0; i < 9; i++) next_burst(int'($urandom_range(511, 256)), int'($urandom_range(1023, 0)), 0, -1);

    // Partial frame restarted by a new frame start.
    pulse_cap();
    model_frame_start();
    chk_frame("drop");
    next_burst(256, 0, 0, 0);

    // Ethernet request with no completed frame.
    pulse_eth();
    model_eth();
    eth_fifo_space = LW'(512);
    repeat (6) begin @(negedge clk); chk("eth_ignored_no_rd", mem_rd_req, 0); end
    eth_fifo_space = '0;
    chk_frame("eth_ignored");

    // Fill bank 0; the frame start arrives while the last burst is busy.
    while (m_wr_off < FW - BL) next_burst(int'($urandom_range(1023, 256)), int'($urandom_range(1023, 0)), 0, -1);
    next_burst(int'($urandom_range(1023, 256)), 0, 1, 0);
    @(negedge clk);
    model_frame_start();
    chk_frame("frame1");
    chk("frame1_ready_set", frame_ready, 1);
    next_burst(256, 0, 0, 0);

    // Start reading the completed frame, then check arbitration patterns.
    pulse_eth();
    model_eth();
    chk_frame("eth_start");
    next_burst(0, 512, 0, 1);
    next_burst(300, 512, 0, 0);
    next_burst(300, 512, 0, 1);
    next_burst(300, 512, 0, 0);
    for (int i = 0; i < 3; i++) next_burst(600, 512, 0, 0);

    // Finish the bank-1 frame with reads interleaved; reader holds bank 0.
    while (m_wr_off < FW) next_burst(int'($urandom_range(1023, 256)), int'($urandom_range(1023, 0)), 0, -1);
    pulse_cap();
    model_frame_start();
    chk_frame("reuse");
    next_burst(256, 0, 0, 0);

    // Reset in the middle of a burst.
    cap_fifo_level = LW'(256);
    n = 0;
    while (!mem_wr_req && n < 40) begin @(negedge clk); n++; end
    chk("rst_mid_req_seen", mem_wr_req, 1);
    mem_ack = 1'b1; @(negedge clk); mem_ack = 1'b0;
    rst_n = 1'b0; mem_init_done = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_wr_req", mem_wr_req, 0);
    chk("rst_mid_addr", mem_addr, 0);
    chk_frame("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    cap_fifo_level = LW'(512);
    pulse_cap();
    repeat (8) begin @(negedge clk); chk("rst_mid_no_req", mem_wr_req | mem_rd_req, 0); end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
